// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sequence: inhibit the bus, request-to-send, shift an 11-bit frame on
// device clocks, check the device ACK, then report completion.
// The pads are open-collector: a 1 on an *_oe output pulls the line low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       RSTN,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // The start bit goes onto the bus one cycle before the clock is released,
    // so the clock stays low for exactly INHIBIT_CYCLES cycles in total.
    localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;
    localparam logic [2:0] S_ABORT     = 3'd6;

    logic [2:0]       state;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;

    logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic ps2_dat_p0, ps2_dat_p1;
    logic clk_fall;
    logic to_hit;
    logic frame_adv;

    // Pad synchronisers; the third clock stage is the previous sample for edge detection.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            ps2_clk_p0 <= 1'b1;
            ps2_clk_p1 <= 1'b1;
            ps2_clk_p2 <= 1'b1;
            ps2_dat_p0 <= 1'b1;
            ps2_dat_p1 <= 1'b1;
        end else begin
            ps2_clk_p0 <= ps2_clk_i;
            ps2_clk_p1 <= ps2_clk_p0;
            ps2_clk_p2 <= ps2_clk_p1;
            ps2_dat_p0 <= ps2_dat_i;
            ps2_dat_p1 <= ps2_dat_p0;
        end
    end

    assign clk_fall   = ~ps2_clk_p1 & ps2_clk_p2;
    assign to_hit     = (to_cnt == TO_LAST);
    assign frame_adv  = ((state == S_REQ) || (state == S_SHIFT)) && clk_fall && !to_hit;
    assign rx_inhibit = busy;

    // Frame register: loaded on an accepted write, shifted right as each bit is driven.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && wr) begin
            frame <= {1'b1, ~^wdata, wdata};
        end else if (frame_adv) begin
            frame <= {1'b1, frame[9:1]};
        end
    end

    // Transaction sequencer: inhibit, request-to-send, shift, ACK, bus idle.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state      <= S_IDLE;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            timeout    <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (wr) begin
                        ack_err    <= 1'b0;
                        timeout    <= 1'b0;
                        busy       <= 1'b1;
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_START) begin
                        ps2_dat_oe <= 1'b1;
                    end
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        to_cnt     <= '0;
                        state      <= S_REQ;
                    end
                end
                S_REQ, S_SHIFT, S_ACK: begin
                    if (to_hit) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        state      <= S_ABORT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (clk_fall) begin
                            case (state)
                                S_REQ: begin
                                    ps2_dat_oe <= ~frame[0];
                                    bit_cnt    <= 4'd1;
                                    state      <= S_SHIFT;
                                end
                                S_SHIFT: begin
                                    ps2_dat_oe <= ~frame[0];
                                    bit_cnt    <= bit_cnt + 1'b1;
                                    if (bit_cnt == 4'd9) begin
                                        state <= S_ACK;
                                    end
                                end
                                default: begin
                                    ack_err <= ps2_dat_p1;
                                    state   <= S_WAIT_IDLE;
                                end
                            endcase
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (ps2_clk_p1 && ps2_dat_p1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_ABORT: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a behavioural PS/2 device,
// a scoreboard of expected transaction outcomes and a done-driven monitor.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 5000;
    localparam int HALF = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RSTN;
    logic       wr;
    logic [7:0] wdata;
    logic       busy, done, ack_err, timeout;
    logic       ps2_clk_oe, ps2_dat_oe, rx_inhibit;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .wr        (wr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .timeout   (timeout),
        .ps2_clk_i (clk_line),
        .ps2_dat_i (dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .rx_inhibit(rx_inhibit)
    );

    typedef struct {
        logic [10:0] frame;
        bit          has_frame;
        bit          ack_err;
        bit          tmo;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] rx_q[$];
    int          cmp_n  = 0;
    int          mis_n  = 0;
    int          done_n = 0;
    int          fall_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_n++;
        if (act !== req) begin
            mis_n++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        cmp_n++;
        mis_n++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Reference frame as the device should see it on the wire:
    // start 0, data LSB first, odd parity, stop 1 (bit 0 = start).
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Completion monitor: pops the scoreboard whenever done is seen.
    exp_t        m_e;
    logic [10:0] m_rx;
    logic        done_q = 1'b0;
    always @(negedge clk) begin
        if (RSTN === 1'b1 && done === 1'b1) begin
            done_n++;
            chk("done_single_cycle", done_q, 1'b0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                m_e = exp_q.pop_front();
                chk("ack_err", ack_err, m_e.ack_err);
                chk("timeout", timeout, m_e.tmo);
                chk("busy_at_done", busy, 1'b0);
                chk("rx_inhibit_at_done", rx_inhibit, 1'b0);
                if (m_e.has_frame) begin
                    if (rx_q.size() == 0) begin
                        fail_now("frame_not_received");
                    end else begin
                        m_rx = rx_q.pop_front();
                        chk("device_frame", m_rx, m_e.frame);
                    end
                end
            end
        end
        done_q = done;
    end

    // Inhibit monitor: clock held low for exactly INH cycles, start bit already driven at release.
    int   low_run  = 0;
    logic clk_oe_q = 1'b0;
    logic dat_oe_q = 1'b0;
    always @(negedge clk) begin
        if (RSTN === 1'b1 && ps2_clk_oe === 1'b0 && clk_oe_q === 1'b1) begin
            chk("inhibit_length", low_run, INH);
            chk("start_bit_before_release", dat_oe_q, 1'b1);
        end
        low_run  = (ps2_clk_oe === 1'b1) ? low_run + 1 : 0;
        clk_oe_q = ps2_clk_oe;
        dat_oe_q = ps2_dat_oe;
    end

    // Behavioural device: mode 0 = ACK, 1 = NACK, 2 = never clocks.
    // stop_after > 0 abandons the frame after that many falling edges.
    task automatic dev_frame(input int mode, input int stop_after);
        logic [10:0] rx;
        int n;
        n = 0;
        while (!(clk_line === 1'b1 && dat_line === 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            fail_now("request_to_send");
            return;
        end
        if (mode == 2) return;
        rx    = '0;
        rx[0] = dat_line;
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            fall_n++;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (fall_n == stop_after) return;
            repeat (HALF / 2) @(negedge clk);
            rx[i] = dat_line;
            repeat (HALF / 2) @(negedge clk);
        end
        rx_q.push_back(rx);
        if (mode == 0) dev_dat_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int mode, input bit track);
        exp_t e;
        e.frame     = model_frame(b);
        e.has_frame = (mode != 2);
        e.ack_err   = (mode == 1);
        e.tmo       = (mode == 2);
        if (track) exp_q.push_back(e);
        @(negedge clk);
        wr    = 1'b1;
        wdata = b;
        @(negedge clk);
        wr = 1'b0;
        chk("busy_on_accept", busy, 1'b1);
        chk("rx_inhibit_on_accept", rx_inhibit, 1'b1);
        chk("ack_err_cleared", ack_err, 1'b0);
        chk("timeout_cleared", timeout, 1'b0);
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_n == prev && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail_now("done_wait");
        repeat (3) @(negedge clk);
    endtask

    task automatic txn(input logic [7:0] b, input int mode);
        int prev;
        prev = done_n;
        send(b, mode, 1'b1);
        dev_frame(mode, 0);
        wait_done(prev);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int n;
        logic [7:0] rb;
        int rm;

        RSTN  = 1'b0;
        wr    = 1'b0;
        wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("rst_flags", {ack_err, timeout}, 2'b00);
        RSTN = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);

        // Directed commands and parity corners.
        txn(8'hED, 0);
        txn(8'h00, 0);
        txn(8'hFF, 0);
        txn(8'h01, 0);

        // NACK, then the next accepted write clears ack_err (checked in send).
        txn(8'hF2, 1);
        chk("ack_err_held", ack_err, 1'b1);

        // Write while busy must be ignored.
        prev = done_n;
        send(8'hF4, 0, 1'b1);
        fork
            dev_frame(0, 0);
            begin
                repeat (1500) @(negedge clk);
                wr    = 1'b1;
                wdata = 8'hAA;
                @(negedge clk);
                wr = 1'b0;
                chk("busy_mid_frame", busy, 1'b1);
            end
        join
        wait_done(prev);
        repeat (200) @(negedge clk);
        chk("ignored_wr_no_txn", busy, 1'b0);
        chk("single_done", done_n, prev + 1);

        // Silent device: abort after TO cycles in REQ.
        prev = done_n;
        send(8'h3C, 2, 1'b1);
        dev_frame(2, 0);
        n = 0;
        while (timeout !== 1'b1 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, TO);
        chk("timeout_oe_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("timeout_done_not_yet", done, 1'b0);
        @(negedge clk);
        chk("timeout_done_next", done, 1'b1);
        wait_done(prev);

        // Asynchronous reset mid-frame.
        fall_n = 0;
        send(8'hC3, 0, 1'b0);
        fork
            dev_frame(0, 5);
            begin
                n = 0;
                while (fall_n < 5 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 5000) fail_now("reset_point");
                repeat (10) @(negedge clk);
                RSTN = 1'b0;
                #1;
                chk("reset_clk_oe", ps2_clk_oe, 1'b0);
                chk("reset_dat_oe", ps2_dat_oe, 1'b0);
                chk("reset_busy", busy, 1'b0);
            end
        join
        repeat (5) @(negedge clk);
        RSTN = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", busy, 1'b0);
        txn(8'hFF, 0);

        // Randomised commands with random ACK/NACK.
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom);
            rm = int'($urandom_range(0, 1));
            txn(rb, rm);
        end

        repeat (100) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("rx_drained", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
        $finish;
    end

endmodule
